lsu_mem_master: RTL

//  Load/store initiator between the MIPS MEM stage and the word-addressed data RAM (combinational read, negedge write).

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_mem_master_if.sv | 27 ++
 rtl/lsu_lane_merge.sv | 29 ++
 rtl/lsu_mem_master.sv | 76 +++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, op classification helpers, FSM state encoding and lane widths
package lsu_pkg;
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_e;
    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic logic is_legal(input logic [3:0] op);
        return is_load(op) | is_store(op);
    endfunction
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        return (op inside {OP_LH, OP_LHU, OP_SH} && a[0]) || (op inside {OP_LW, OP_SW} && a != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: MEM-stage request/response handshake plus data RAM port
interface lsu_mem_master_if #(
    parameter int ADDRESS_SIZE  = 32,
    parameter int DATA_SIZE     = 32,
    parameter int RAM_ADDR_BITS = 8
);
    logic                     i_req_valid;
    logic                     o_req_ready;
    logic [3:0]               i_op;
    logic [ADDRESS_SIZE-1:0]  i_addr;
    logic [DATA_SIZE-1:0]     i_wdata;
    logic                     o_resp_valid;
    logic [DATA_SIZE-1:0]     o_rdata;
    logic                     o_exc;
    logic [RAM_ADDR_BITS-1:0] o_ram_addr;
    logic [DATA_SIZE-1:0]     o_ram_wdata;
    logic                     o_ram_w_enable;
    logic [DATA_SIZE-1:0]     i_ram_rdata;
    modport master (
        input  i_req_valid, i_op, i_addr, i_wdata, i_ram_rdata,
        output o_req_ready, o_resp_valid, o_rdata, o_exc, o_ram_addr, o_ram_wdata, o_ram_w_enable
    );
    modport slave (
        output i_req_valid, i_op, i_addr, i_wdata, i_ram_rdata,
        input  o_req_ready, o_resp_valid, o_rdata, o_exc, o_ram_addr, o_ram_wdata, o_ram_w_enable
    );
endinterface

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge: little-endian lane extract/extend for loads and lane insert for SB/SH
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_ext,
    output logic [WORD_W-1:0] merged
);
    logic [4:0]        bsh;
    logic [4:0]        hsh;
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    always_comb begin
        bsh = {lane, 3'b000};
        hsh = {lane[1], 4'b0000};
        b = BYTE_W'(word >> bsh);
        h = HALF_W'(word >> hsh);
        load_ext = op == OP_LB  ? {{24{b[7]}}, b} :
                   op == OP_LBU ? {24'b0, b} :
                   op == OP_LH  ? {{16{h[15]}}, h} :
                   op == OP_LHU ? {16'b0, h} :
                   op == OP_LW  ? word : '0;
        merged = op == OP_SB ? (word & ~(32'hFF << bsh)) | ({24'b0, wdata[7:0]} << bsh) :
                 op == OP_SH ? (word & ~(32'hFFFF << hsh)) | ({16'b0, wdata[15:0]} << hsh) : wdata;
    end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MIPS load/store initiator to a word RAM with RMW sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH/LW/SW instead of aligning down.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 32,
    parameter int DATA_SIZE     = 32,
    parameter int RAM_ADDR_BITS = 8
) (
    input logic clk,
    input logic rst,
    lsu_mem_master_if.master bus
);
    state_e                   st, st_nx;
    logic [3:0]               op_q;
    logic [RAM_ADDR_BITS+1:0] addr_q;
    logic [WORD_W-1:0]        wdata_q;
    logic [WORD_W-1:0]        data_q;
    logic                     exc_q;
    logic                     accept;
    logic                     trap_now;
    logic [WORD_W-1:0]        load_ext;
    logic [WORD_W-1:0]        merged;
    assign accept = bus.i_req_valid & bus.o_req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_now = is_legal(bus.i_op) & is_misaligned(bus.i_op, bus.i_addr[1:0]);
`else
    assign trap_now = 1'b0;
`endif
    // MERGE works on the word captured in ACCESS; loads extend the live RAM word
    lsu_lane_merge u_lane (
        .op       (op_q),
        .lane     (addr_q[1:0]),
        .word     (st == S_MERGE ? data_q : bus.i_ram_rdata),
        .wdata    (wdata_q),
        .load_ext (load_ext),
        .merged   (merged)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= S_IDLE;
        else     st <= st_nx;
    always_comb begin
        st_nx = st;
        case (st)
            S_IDLE:   if (accept) st_nx = trap_now ? S_RESP : S_ACCESS;
            S_ACCESS: st_nx = (op_q == OP_SB || op_q == OP_SH) ? S_MERGE : S_RESP;
            S_MERGE:  st_nx = S_RESP;
            default:  st_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.i_op;
                addr_q  <= bus.i_addr[RAM_ADDR_BITS+1:0];
                wdata_q <= bus.i_wdata;
                exc_q   <= ~is_legal(bus.i_op) | trap_now;
            end
            if (st == S_ACCESS) data_q <= is_load(op_q) ? load_ext : bus.i_ram_rdata;
        end
    always_comb begin
        bus.o_req_ready    = (st == S_IDLE) & ~rst;
        bus.o_resp_valid   = st == S_RESP;
        bus.o_exc          = (st == S_RESP) & exc_q;
        bus.o_rdata        = (st == S_RESP && is_load(op_q) && !exc_q) ? data_q : '0;
        bus.o_ram_w_enable = (st == S_ACCESS && op_q == OP_SW) || st == S_MERGE;
        bus.o_ram_wdata    = st == S_MERGE ? merged : (st == S_ACCESS && op_q == OP_SW) ? wdata_q : '0;
        bus.o_ram_addr     = ((st == S_ACCESS || st == S_MERGE) && is_legal(op_q)) ? addr_q[RAM_ADDR_BITS+1:2] : '0;
    end
endmodule
